// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the pipeline control blocks
package core_pkg;
   typedef enum logic [1:0] {RUN, REDIRECT, MEM_WAIT} hz_state_t;
   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] X0 = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge i_clk)
      r_cnt <= i_rst ? '0 : (i_inc && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
   assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: load-use stall, taken-branch flush and memory-wait freeze
// control for the 5-stage pipeline, with saturating stall/flush counters.
module hazard_flush_ctrl
   import core_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_uses_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_MemRead,
   input  logic                 mem_branch_taken,
   input  logic                 mem_busy,
   output logic                 PC_write,
   output logic                 IF_ID_write,
   output logic                 IF_ID_flush,
   output logic                 ID_EX_flush,
   output logic                 EX_MEM_flush,
   output logic                 pipe_hold,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);
   hz_state_t r_state, w_next;
   logic w_lu, w_freeze, w_br;
   always_comb begin
      w_lu = ex_MemRead && ex_rd != X0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
      // MEM_WAIT with busy low falls through to the RUN decode below
      w_freeze = (r_state == MEM_WAIT && mem_busy) || (r_state == RUN && !mem_branch_taken && mem_busy);
      w_next = RUN;
      w_br = 1'b0;
      PC_write = 1'b1;
      IF_ID_write = 1'b1;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
      EX_MEM_flush = 1'b0;
      pipe_hold = 1'b0;
      if (reset) begin
         PC_write = 1'b0;
         IF_ID_write = 1'b0;
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
         EX_MEM_flush = 1'b1;
      end else if (r_state == REDIRECT) begin
         IF_ID_flush = 1'b1;
      end else if (w_freeze) begin
         PC_write = 1'b0;
         IF_ID_write = 1'b0;
         pipe_hold = 1'b1;
         w_next = MEM_WAIT;
      end else if (mem_branch_taken) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
         EX_MEM_flush = 1'b1;
         w_br = 1'b1;
         w_next = REDIRECT;
      end else if (w_lu) begin
         PC_write = 1'b0;
         IF_ID_write = 1'b0;
         ID_EX_flush = 1'b1;
      end
   end
   always_ff @(posedge clk)
      r_state <= reset ? RUN : w_next;
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk(clk),
      .i_rst(reset),
      .i_inc(!PC_write && !reset),
      .o_cnt(stall_cnt)
   );
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk(clk),
      .i_rst(reset),
      .i_inc(w_br),
      .o_cnt(flush_cnt)
   );
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb_hazard_flush_ctrl: directed and random stimulus against a rule-level
// model of the hazard controller; a 2-bit-counter instance shares the inputs.
module tb_hazard_flush_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs2, ex_MemRead, mem_branch_taken, mem_busy;
   logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_hold;
   logic PC_write_s, IF_ID_write_s, IF_ID_flush_s, ID_EX_flush_s, EX_MEM_flush_s, pipe_hold_s;
   logic [31:0] stall_cnt, flush_cnt;
   logic [1:0] stall_cnt_s, flush_cnt_s;
   int n_chk = 0;
   int n_err = 0;
   bit m_redir, m_wait;
   longint m_stall, m_flush;
   longint s0;

   always #5 clk = ~clk;

   hazard_flush_ctrl dut (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
      .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush), .pipe_hold(pipe_hold),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_flush_ctrl #(.CNT_W(2)) dut_sm (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
      .PC_write(PC_write_s), .IF_ID_write(IF_ID_write_s), .IF_ID_flush(IF_ID_flush_s),
      .ID_EX_flush(ID_EX_flush_s), .EX_MEM_flush(EX_MEM_flush_s), .pipe_hold(pipe_hold_s),
      .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint sat(input longint v, input int w);
      longint mx = (64'sd1 <<< w) - 1;
      return v > mx ? mx : v;
   endfunction

   // Drive one cycle, check mid-cycle against the model, then advance the model at the edge.
   task automatic step(input logic [4:0] rs1, rs2, input logic uses, input logic [4:0] rd,
                       input logic mr, br, busy, rst);
      bit lu, br_ok, stall;
      logic [5:0] exp;
      id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses; ex_rd = rd;
      ex_MemRead = mr; mem_branch_taken = br; mem_busy = busy; reset = rst;
      #4;
      lu = mr && rd != 0 && (rd == rs1 || (uses && rd == rs2));
      br_ok = 0;
      // field order: PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_hold
      if (rst) exp = 6'b001110;
      else if (m_redir) exp = 6'b111000;
      else if (m_wait && busy) exp = 6'b000001;
      else if (br) begin exp = 6'b111110; br_ok = 1; end
      else if (busy) exp = 6'b000001;
      else if (lu) exp = 6'b000100;
      else exp = 6'b110000;
      chk("ctl", {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_hold}, exp);
      chk("ctl_sm", {PC_write_s, IF_ID_write_s, IF_ID_flush_s, ID_EX_flush_s, EX_MEM_flush_s, pipe_hold_s}, exp);
      chk("stall_cnt", stall_cnt, sat(m_stall, 32));
      chk("flush_cnt", flush_cnt, sat(m_flush, 32));
      chk("stall_cnt_sm", stall_cnt_s, sat(m_stall, 2));
      chk("flush_cnt_sm", flush_cnt_s, sat(m_flush, 2));
      stall = !exp[5] && !rst;
      @(posedge clk);
      if (rst) begin
         m_redir = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      end else begin
         m_wait = !m_redir && busy && !br_ok;
         m_redir = br_ok;
         m_stall += stall;
         m_flush += br_ok;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 2, 1, 3, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_rd = 0;
      ex_MemRead = 0; mem_branch_taken = 0; mem_busy = 0;
      m_redir = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      @(posedge clk); #1;
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk("reset_stall", stall_cnt, 0);
      chk("reset_flush", flush_cnt, 0);
      idle(1);
      step(5, 0, 0, 5, 1, 0, 0, 0);
      chk("lu_stall", stall_cnt, 1);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      step(0, 7, 0, 7, 1, 0, 0, 0);
      chk("rs2_unused", stall_cnt, 1);
      step(0, 7, 1, 7, 1, 0, 0, 0);
      chk("rs2_used", stall_cnt, 2);
      step(1, 2, 1, 3, 0, 1, 0, 0);
      step(1, 2, 1, 3, 0, 1, 1, 0);
      idle(1);
      chk("branch_flush", flush_cnt, 1);
      s0 = m_stall;
      for (int i = 0; i < 3; i++) step(5, 0, 0, 5, 1, 0, 1, 0);
      step(5, 0, 0, 5, 1, 0, 0, 0);
      chk("memwait_stall", stall_cnt - s0[31:0], 4);
      idle(1);
      step(1, 2, 1, 3, 0, 1, 1, 0);
      chk("prio_flush", flush_cnt, 2);
      idle(1);
      for (int i = 0; i < 4; i++) step(1, 2, 1, 3, 0, 0, 1, 0);
      step(1, 2, 1, 3, 0, 0, 1, 1);
      chk("mid_wait_rst_stall", stall_cnt, 0);
      chk("mid_wait_rst_flush", flush_cnt, 0);
      for (int i = 0; i < 5; i++) step(1, 2, 1, 3, 0, 0, 1, 0);
      chk("sat_stall_sm", stall_cnt_s, 3);
      chk("nosat_stall", stall_cnt, 5);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 15,
              $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
